// File: rtl/register_file.sv
// Architectural register file: two bypassed combinational read ports, writeback
// and call-link write ports, and a per-register busy scoreboard for RAW hazard stalls.
module register_file #(
  parameter int              NREGS   = 16,
  parameter int              WIDTH   = 32,
  parameter logic [WIDTH-1:0] SP_INIT = 32'h0000_0FFC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] reg_addr1,
  input  logic [$clog2(NREGS)-1:0] reg_addr2,
  output logic [WIDTH-1:0]         reg_data1,
  output logic [WIDTH-1:0]         reg_data2,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [WIDTH-1:0]         wb_data,
  input  logic                     isCall,
  input  logic [WIDTH-1:0]         call_pc,
  input  logic                     rsv_en,
  input  logic [$clog2(NREGS)-1:0] rsv_addr,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     stall,
  output logic [$clog2(NREGS):0]   busy_cnt
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] RA_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] SP_IDX = AW'(NREGS - 2);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clear_vec;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] busy_next;
  logic [WIDTH-1:0] link_val;

  assign link_val = call_pc + WIDTH'(4);

  always_comb begin
    clear_vec = '0;
    if (wb_en)  clear_vec[wb_addr] = 1'b1;
    if (isCall) clear_vec[RA_IDX]  = 1'b1;
  end

  always_comb begin
    set_vec = '0;
    if (rsv_en && !stall) set_vec[rsv_addr] = 1'b1;
  end

  // set after clear: a fresh reservation is younger than the retiring write
  assign busy_next = (busy & ~clear_vec) | set_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (AW'(i) == SP_IDX) ? SP_INIT : '0;
      busy <= '0;
    end else begin
      if (wb_en)  regs[wb_addr] <= wb_data;
      if (isCall) regs[RA_IDX]  <= link_val;
      busy <= busy_next;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    if (isCall && addr == RA_IDX)
      return link_val;
    else if (wb_en && addr == wb_addr)
      return wb_data;
    else
      return regs[addr];
  endfunction

  assign reg_data1 = read_port(reg_addr1);
  assign reg_data2 = read_port(reg_addr2);

  assign busy1 = busy[reg_addr1] & ~clear_vec[reg_addr1];
  assign busy2 = busy[reg_addr2] & ~clear_vec[reg_addr2];
  assign stall = busy1 | busy2;

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NREGS; i++)
      busy_cnt = busy_cnt + (AW + 1)'(busy[i]);
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, bypass, call link,
// scoreboard flow, set/clear collision and reset in flight.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [3:0]  reg_addr1, reg_addr2;
  logic [31:0] reg_data1, reg_data2;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        isCall;
  logic [31:0] call_pc;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        busy1, busy2, stall;
  logic [4:0]  busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  register_file dut (
    .clk(clk), .reset(reset),
    .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .reg_data1(reg_data1), .reg_data2(reg_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .isCall(isCall), .call_pc(call_pc),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1), .busy2(busy2), .stall(stall), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_en = 0; isCall = 0; rsv_en = 0;
    wb_addr = 0; wb_data = 0; call_pc = 0; rsv_addr = 0;
  endtask

  task automatic test_reset();
    step();
    wb_en = 1; wb_addr = 3; wb_data = 32'h33;
    step();
    wb_addr = 14; wb_data = 32'h1234;
    step();
    idle_inputs();
    #3 reset = 1;
    #1 reg_addr1 = 3;
    #1;
    n_cmp++;
    if (reg_data1 !== 32'h0) begin
      n_err++; $display("FAIL reset_r3 got %h exp %h", reg_data1, 32'h0);
    end
    reg_addr1 = 14;
    #1;
    n_cmp++;
    if (reg_data1 !== 32'h0000_0FFC) begin
      n_err++; $display("FAIL reset_r14 got %h exp %h", reg_data1, 32'h0000_0FFC);
    end
    n_cmp++;
    if (busy_cnt !== 5'd0 || stall !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got cnt=%0d stall=%b exp cnt=0 stall=0", busy_cnt, stall);
    end
    reset = 0;
    reg_addr1 = 0;
  endtask

  task automatic test_write_bypass();
    step();
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    reg_addr1 = 5; reg_addr2 = 5;
    #1;
    n_cmp++;
    if (reg_data1 !== 32'hDEADBEEF || reg_data2 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL bypass_r5 got %h/%h exp %h", reg_data1, reg_data2, 32'hDEADBEEF);
    end
    step();
    wb_en = 0;
    #1;
    n_cmp++;
    if (reg_data1 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL stored_r5 got %h exp %h", reg_data1, 32'hDEADBEEF);
    end
  endtask

  task automatic test_call();
    step();
    isCall = 1; call_pc = 32'h100; wb_en = 1; wb_addr = 15; wb_data = 32'h7;
    reg_addr1 = 15;
    #1;
    n_cmp++;
    if (reg_data1 !== 32'h104) begin
      n_err++; $display("FAIL call_bypass got %h exp %h", reg_data1, 32'h104);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (reg_data1 !== 32'h104) begin
      n_err++; $display("FAIL call_stored got %h exp %h", reg_data1, 32'h104);
    end
    step();
    isCall = 1; call_pc = 32'hFFFF_FFFC; wb_en = 1; wb_addr = 15; wb_data = 32'h7;
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (reg_data1 !== 32'h0) begin
      n_err++; $display("FAIL call_wrap got %h exp %h", reg_data1, 32'h0);
    end
    step();
    isCall = 1; call_pc = 32'h200; wb_en = 1; wb_addr = 6; wb_data = 32'h7;
    step();
    idle_inputs();
    reg_addr2 = 6;
    #1;
    n_cmp++;
    if (reg_data1 !== 32'h204 || reg_data2 !== 32'h7) begin
      n_err++; $display("FAIL call_dual got r15=%h r6=%h exp r15=%h r6=%h", reg_data1, reg_data2, 32'h204, 32'h7);
    end
  endtask

  task automatic test_scoreboard();
    step();
    reg_addr1 = 0; reg_addr2 = 0;
    rsv_en = 1; rsv_addr = 2;
    step();
    rsv_en = 0; reg_addr2 = 2;
    #1;
    n_cmp++;
    if (busy2 !== 1'b1 || stall !== 1'b1 || busy_cnt !== 5'd1) begin
      n_err++; $display("FAIL rsv_r2 got busy2=%b stall=%b cnt=%0d exp 1 1 1", busy2, stall, busy_cnt);
    end
    rsv_en = 1; rsv_addr = 3;
    step();
    rsv_en = 0; reg_addr1 = 3;
    #1;
    n_cmp++;
    if (busy_cnt !== 5'd1 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL rsv_ignored got cnt=%0d busy1=%b exp cnt=1 busy1=0", busy_cnt, busy1);
    end
    wb_en = 1; wb_addr = 2; wb_data = 32'h55;
    #1;
    n_cmp++;
    if (busy2 !== 1'b0 || stall !== 1'b0 || reg_data2 !== 32'h55) begin
      n_err++; $display("FAIL wb_clear got busy2=%b stall=%b data2=%h exp 0 0 %h", busy2, stall, reg_data2, 32'h55);
    end
    n_cmp++;
    if (busy_cnt !== 5'd1) begin
      n_err++; $display("FAIL wb_cnt_lag got %0d exp %0d", busy_cnt, 1);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (busy_cnt !== 5'd0) begin
      n_err++; $display("FAIL wb_cnt got %0d exp %0d", busy_cnt, 0);
    end
  endtask

  task automatic test_collision();
    step();
    reg_addr1 = 0; reg_addr2 = 0;
    rsv_en = 1; rsv_addr = 4;
    step();
    rsv_en = 1; rsv_addr = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h9;
    #1;
    n_cmp++;
    if (busy_cnt !== 5'd1 || stall !== 1'b0) begin
      n_err++; $display("FAIL coll_pre got cnt=%0d stall=%b exp cnt=1 stall=0", busy_cnt, stall);
    end
    step();
    idle_inputs();
    reg_addr1 = 4;
    #1;
    n_cmp++;
    if (busy1 !== 1'b1 || busy_cnt !== 5'd1 || reg_data1 !== 32'h9) begin
      n_err++; $display("FAIL coll_post got busy1=%b cnt=%0d data=%h exp 1 1 %h", busy1, busy_cnt, reg_data1, 32'h9);
    end
    wb_en = 1; wb_addr = 4; wb_data = 32'h9;
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (busy_cnt !== 5'd0 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL coll_drain got cnt=%0d busy1=%b exp 0 0", busy_cnt, busy1);
    end
  endtask

  task automatic test_reset_midflight();
    reg_addr1 = 0; reg_addr2 = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      wb_en = 1; wb_addr = 4'(i); wb_data = 32'(i * 32'h11);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      idle_inputs();
      rsv_en = 1; rsv_addr = 4'(i);
    end
    step();
    idle_inputs();
    wb_en = 1; wb_addr = 7; wb_data = 32'h77;
    reg_addr1 = 2;
    #1;
    n_cmp++;
    if (busy_cnt !== 5'd3 || reg_data1 !== 32'h22) begin
      n_err++; $display("FAIL mid_pre got cnt=%0d r2=%h exp cnt=3 r2=%h", busy_cnt, reg_data1, 32'h22);
    end
    #2 reset = 1;
    #1;
    n_cmp++;
    if (busy_cnt !== 5'd0) begin
      n_err++; $display("FAIL mid_cnt got %0d exp %0d", busy_cnt, 0);
    end
    wb_en = 0;
    for (int i = 1; i <= 3; i++) begin
      reg_addr1 = 4'(i);
      #0.5;
      n_cmp++;
      if (reg_data1 !== 32'h0) begin
        n_err++; $display("FAIL mid_r%0d got %h exp %h", i, reg_data1, 32'h0);
      end
    end
    reset = 0;
    step();
    reg_addr1 = 7;
    #1;
    n_cmp++;
    if (reg_data1 !== 32'h0 || busy_cnt !== 5'd0) begin
      n_err++; $display("FAIL mid_lost got r7=%h cnt=%0d exp 0 0", reg_data1, busy_cnt);
    end
  endtask

  initial begin
    reset = 1;
    reg_addr1 = 0; reg_addr2 = 0;
    idle_inputs();
    #23 reset = 0;
    test_reset();
    test_write_bypass();
    test_call();
    test_scoreboard();
    test_collision();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
